ctl_trigger: RTL and testbench
==============================

Name: ctl_trigger

Overview:
- Producer side of the shot interface consumed by the ammo counter. It conditions the raw mouse/button trigger and emits one clean `shot_fired` pulse per accepted trigger pull.
- Latches the cursor position at the moment of the shot for hit detection.
- Enforces a fire-rate cooldown and suppresses shots while `no_ammo` is high.
- Sits between the mouse/IO layer and `ctl_ammo` / hit-detection logic in the control path.

Parameters:
- DEBOUNCE_CYCLES, 650_000, consecutive stable cycles required before the synchronized trigger level is accepted (10 ms at 65 MHz).
- COOLDOWN_CYCLES, 19_500_000, cycles spent in COOLDOWN after each shot (300 ms); legal range is ≥ 2.
- AUTOFIRE_PERIOD, 13_000_000, extra cycles between repeated shots; used only with TRIGGER_AUTOFIRE_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- reset_score  in  1  synchronous game restart; same effect as rst
- trigger_in  in  1  raw, asynchronous, active-high trigger button
- no_ammo  in  1  registered empty flag from the ammo counter
- xpos  in  12  current cursor X
- ypos  in  12  current cursor Y
- shot_fired  out  1  one-cycle shot pulse
- shot_xpos  out  12  X latched on the shot
- shot_ypos  out  12  Y latched on the shot
- dry_fire  out  1  one-cycle pulse when a pull is rejected for no ammo
- ready  out  1  high only in IDLE

Behaviour:
- Reset values (rst or reset_score): FSM = IDLE; shot_fired = 0, dry_fire = 0; shot_xpos = shot_ypos = 0; ready = 1. Synchronizer and debouncer clear to 0. Reset mid-COOLDOWN aborts immediately.
- Input path: trigger_in passes through a 2-flop synchronizer. The debouncer counts cycles in which the synchronized input differs from the debounced level. The debounced level toggles when the count reaches DEBOUNCE_CYCLES; any agreeing cycle clears the count. A pull is the rising edge of the debounced level.
- Latency: a clean raw rising edge gives shot_fired high exactly 2 + DEBOUNCE_CYCLES + 1 cycles later.
- FSM states:
  - IDLE: ready = 1. On a pull with no_ammo = 0, go to FIRE. On a pull with no_ammo = 1, pulse dry_fire for 1 cycle and stay in IDLE.
  - FIRE: exactly 1 cycle. shot_fired = 1. shot_xpos/shot_ypos load xpos/ypos sampled that cycle and hold until the next FIRE. Next state is COOLDOWN, counter = 0.
  - COOLDOWN: shot_fired = 0. Counts up to COOLDOWN_CYCLES-1. Then go to WAIT_RELEASE if the debounced level is 1, else IDLE. Pulls during COOLDOWN are ignored, not queued.
  - WAIT_RELEASE: stay until the debounced level = 0, then go to IDLE. Prevents a held button refiring.
- shot_fired is low for ≥ COOLDOWN_CYCLES between pulses, so the consumer's rising-edge detector sees every shot. COOLDOWN_CYCLES ≥ 2 guarantees the consumer's registered no_ammo is current before the next IDLE decision.
- No glitch: shot_fired and dry_fire are registered and never assert in the same cycle.
- Counters are sized with $clog2 of the parameter and saturate at the terminal count; they never wrap.

Optional Feature:
- Macro: TRIGGER_AUTOFIRE_EN.
- Defined: at the end of COOLDOWN with the debounced level still 1, enter AUTOWAIT for AUTOFIRE_PERIOD cycles.
  - Still held and no_ammo = 0: go to FIRE.
  - Held but no_ammo = 1: pulse dry_fire once, then WAIT_RELEASE.
  - Released during AUTOWAIT: go to IDLE.
- Undefined: AUTOWAIT does not exist and the held trigger goes to WAIT_RELEASE. AUTOFIRE_PERIOD is unused.

Decomposition:
- Add to vga_pkg:
  - typedef enum logic [2:0] trigger_state_t {IDLE, FIRE, COOLDOWN, WAIT_RELEASE, AUTOWAIT}
  - constants TRIGGER_DEBOUNCE_CYCLES and TRIGGER_COOLDOWN_CYCLES, used as top-level overrides.
- One sub-module, ctl_debounce (parameter CYCLES; ports clk, rst, in, out), containing the synchronizer and stable-count debouncer. The FSM and position latch stay in ctl_trigger.

Test Plan (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, AUTOFIRE_PERIOD=6):
- Clean press at cycle 10, no_ammo = 0, xpos = 100, ypos = 200 -> shot_fired high only at cycle 17; shot_xpos = 100, shot_ypos = 200; ready low for cycles 17–25.
- Trigger bounces 0/1 every 2 cycles for 20 cycles, then stays high -> no shot during the bounce; exactly one shot_fired after 4 stable cycles.
- Hold trigger 40 cycles (macro off) -> exactly one shot_fired; ready returns 1 only after release plus 4 debounce cycles.
- Press with no_ammo = 1 -> dry_fire one-cycle pulse at the cycle shot_fired would have fired; shot_fired stays 0; shot_xpos/shot_ypos unchanged.
- rst asserted at COOLDOWN cycle 3 -> next cycle: IDLE, ready = 1, shot_xpos/shot_ypos = 0. A new press then fires after the full latency.
- Macro on, trigger held 60 cycles, no_ammo = 0 -> shot_fired pulses 15 cycles apart (1 FIRE + 8 COOLDOWN + 6 AUTOWAIT).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared control-path types and constants for the VGA game.
// Holds the trigger FSM state type and the production trigger timing.
package vga_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FIRE,
      COOLDOWN,
      WAIT_RELEASE,
      AUTOWAIT
   } trigger_state_t;

   localparam int unsigned TRIGGER_DEBOUNCE_CYCLES = 650_000;     // 10 ms at 65 MHz
   localparam int unsigned TRIGGER_COOLDOWN_CYCLES = 19_500_000;  // 300 ms
   localparam int unsigned TRIGGER_AUTOFIRE_PERIOD = 13_000_000;

   // Bits needed for a counter running 0 .. n-1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ctl_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer: the output level
// flips only after the synchronized input has disagreed with it for CYCLES cycles.
module ctl_debounce
   import vga_pkg::*;
#(
   parameter int unsigned CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   localparam int unsigned CntW = cnt_width(CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic            level_q;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         if (sync2_q != level_q) begin
            // Terminal count toggles the level and restarts, so the counter never wraps.
            if (cnt_q == CntLast) begin
               level_q <= ~level_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign out = level_q;

endmodule

// File: rtl/ctl_trigger.sv
// Trigger conditioner: one shot pulse per accepted pull, cursor latch, cooldown and
// empty-magazine suppression. Define TRIGGER_AUTOFIRE_EN to refire while held.
module ctl_trigger
   import vga_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = TRIGGER_DEBOUNCE_CYCLES,
   parameter int unsigned COOLDOWN_CYCLES = TRIGGER_COOLDOWN_CYCLES,
   parameter int unsigned AUTOFIRE_PERIOD = TRIGGER_AUTOFIRE_PERIOD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reset_score,
   input  logic        trigger_in,
   input  logic        no_ammo,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   output logic        shot_fired,
   output logic [11:0] shot_xpos,
   output logic [11:0] shot_ypos,
   output logic        dry_fire,
   output logic        ready
);

   localparam int unsigned CntMax = (COOLDOWN_CYCLES > AUTOFIRE_PERIOD) ?
                                    COOLDOWN_CYCLES : AUTOFIRE_PERIOD;
   localparam int unsigned CntW = cnt_width(CntMax);
   localparam logic [CntW-1:0] CoolLast = CntW'(COOLDOWN_CYCLES - 1);
   localparam logic [CntW-1:0] AutoLast = CntW'(AUTOFIRE_PERIOD - 1);

   trigger_state_t  state_q;
   logic [CntW-1:0] cnt_q;
   logic            level_prev_q;
   logic            shot_fired_q;
   logic            dry_fire_q;
   logic            ready_q;
   logic [11:0]     shot_xpos_q;
   logic [11:0]     shot_ypos_q;

   logic rst_all;
   logic level;
   logic pull;

   assign rst_all = rst | reset_score;

   ctl_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk (clk),
      .rst (rst_all),
      .in  (trigger_in),
      .out (level)
   );

   assign pull = level & ~level_prev_q;

   always_ff @(posedge clk) begin
      if (rst_all) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         level_prev_q <= 1'b0;
         shot_fired_q <= 1'b0;
         dry_fire_q   <= 1'b0;
         ready_q      <= 1'b1;
         shot_xpos_q  <= '0;
         shot_ypos_q  <= '0;
      end else begin
         level_prev_q <= level;
         shot_fired_q <= 1'b0;
         dry_fire_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pull) begin
                  if (no_ammo) begin
                     dry_fire_q <= 1'b1;
                  end else begin
                     // Position is captured on entry so it is valid alongside the pulse.
                     state_q      <= FIRE;
                     shot_fired_q <= 1'b1;
                     shot_xpos_q  <= xpos;
                     shot_ypos_q  <= ypos;
                     ready_q      <= 1'b0;
                  end
               end
            end
            FIRE: begin
               state_q <= COOLDOWN;
               cnt_q   <= '0;
            end
            COOLDOWN: begin
               if (cnt_q == CoolLast) begin
                  cnt_q <= '0;
                  if (level) begin
`ifdef TRIGGER_AUTOFIRE_EN
                     state_q <= AUTOWAIT;
`else
                     state_q <= WAIT_RELEASE;
`endif
                  end else begin
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_RELEASE: begin
               if (!level) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end
            end
            AUTOWAIT: begin
`ifdef TRIGGER_AUTOFIRE_EN
               if (!level) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  cnt_q   <= '0;
               end else if (cnt_q == AutoLast) begin
                  cnt_q <= '0;
                  if (no_ammo) begin
                     dry_fire_q <= 1'b1;
                     state_q    <= WAIT_RELEASE;
                  end else begin
                     state_q      <= FIRE;
                     shot_fired_q <= 1'b1;
                     shot_xpos_q  <= xpos;
                     shot_ypos_q  <= ypos;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`else
               state_q <= IDLE;
               ready_q <= 1'b1;
`endif
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign shot_fired = shot_fired_q;
   assign dry_fire   = dry_fire_q;
   assign ready      = ready_q;
   assign shot_xpos  = shot_xpos_q;
   assign shot_ypos  = shot_ypos_q;

endmodule

// File: tb/tb_ctl_trigger.sv
// Directed bench for ctl_trigger with DEBOUNCE=4, COOLDOWN=8, AUTOFIRE=6.
// Cycle k below means k rising edges after the cycle in which an input was driven.
module tb_ctl_trigger;

   logic        clk = 1'b0;
   logic        rst;
   logic        reset_score;
   logic        trigger_in;
   logic        no_ammo;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        shot_fired;
   logic [11:0] shot_xpos;
   logic [11:0] shot_ypos;
   logic        dry_fire;
   logic        ready;

   int errors = 0;
   int checks = 0;
   int shots  = 0;
   int base;

   always #5 clk = ~clk;

   ctl_trigger #(
      .DEBOUNCE_CYCLES (4),
      .COOLDOWN_CYCLES (8),
      .AUTOFIRE_PERIOD (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .reset_score (reset_score),
      .trigger_in  (trigger_in),
      .no_ammo     (no_ammo),
      .xpos        (xpos),
      .ypos        (ypos),
      .shot_fired  (shot_fired),
      .shot_xpos   (shot_xpos),
      .shot_ypos   (shot_ypos),
      .dry_fire    (dry_fire),
      .ready       (ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && !reset_score && shot_fired) shots++;
      if (shot_fired && dry_fire) check("shot_and_dry_exclusive", 32'd1, 32'd0);
   end

   initial begin
      rst = 1'b1; reset_score = 1'b0; trigger_in = 1'b0; no_ammo = 1'b0;
      xpos = 12'd100; ypos = 12'd200;
      tick(3);
      check("rst_shot", 32'(shot_fired), 32'd0);
      check("rst_dry", 32'(dry_fire), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_xpos", 32'(shot_xpos), 32'd0);
      check("rst_ypos", 32'(shot_ypos), 32'd0);
      rst = 1'b0;
      tick(10);

      // Clean press: pulse at k=7, busy k=7..15 (FIRE + 8 COOLDOWN).
      trigger_in = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick(1);
         if (k == 4) trigger_in = 1'b0;
         check("clean_shot", 32'(shot_fired), 32'(k == 7));
         check("clean_ready", 32'(ready), 32'(!(k >= 7 && k <= 15)));
      end
      check("clean_xpos", 32'(shot_xpos), 32'd100);
      check("clean_ypos", 32'(shot_ypos), 32'd200);
      tick(10);

      // Bounce every 2 cycles never reaches 4 stable cycles; then stable high fires once.
      xpos = 12'd300; ypos = 12'd400;
      base = shots;
      for (int i = 0; i < 20; i++) begin
         trigger_in = ((i / 2) % 2) != 0;
         tick(1);
         if (i == 17) check("bounce_no_shot", 32'(shots - base), 32'd0);
      end
      trigger_in = 1'b1;
      tick(18);
      check("bounce_one_shot", 32'(shots - base), 32'd1);
      check("bounce_xpos", 32'(shot_xpos), 32'd300);
      trigger_in = 1'b0;
      tick(20);

      // Long hold: one shot (or 3 with autofire), ready back exactly 7 cycles after release.
      base = shots;
      trigger_in = 1'b1;
      tick(40);
`ifdef TRIGGER_AUTOFIRE_EN
      check("hold_shots", 32'(shots - base), 32'd3);
`else
      check("hold_shots", 32'(shots - base), 32'd1);
`endif
      check("hold_ready_low", 32'(ready), 32'd0);
      trigger_in = 1'b0;
      tick(6);
      check("release_ready_still_low", 32'(ready), 32'd0);
      tick(1);
      check("release_ready_high", 32'(ready), 32'd1);
      tick(10);

      // Empty magazine: dry_fire where the shot would have been, position untouched.
      no_ammo = 1'b1;
      xpos = 12'd111; ypos = 12'd222;
      trigger_in = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         if (k == 4) trigger_in = 1'b0;
         check("dry_pulse", 32'(dry_fire), 32'(k == 7));
         check("dry_no_shot", 32'(shot_fired), 32'd0);
         check("dry_ready", 32'(ready), 32'd1);
      end
      check("dry_xpos_kept", 32'(shot_xpos), 32'd300);
      check("dry_ypos_kept", 32'(shot_ypos), 32'd400);
      no_ammo = 1'b0;
      tick(10);

      // Reset during COOLDOWN (counter value 3 at k=11) aborts at once.
      xpos = 12'd500; ypos = 12'd600;
      trigger_in = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick(1);
         if (k == 4) trigger_in = 1'b0;
         if (k == 7) check("pre_rst_shot", 32'(shot_fired), 32'd1);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midcool_rst_ready", 32'(ready), 32'd1);
      check("midcool_rst_xpos", 32'(shot_xpos), 32'd0);
      check("midcool_rst_ypos", 32'(shot_ypos), 32'd0);
      trigger_in = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         if (k == 4) trigger_in = 1'b0;
         check("post_rst_shot", 32'(shot_fired), 32'(k == 7));
      end
      check("post_rst_xpos", 32'(shot_xpos), 32'd500);

      // reset_score behaves like rst.
      reset_score = 1'b1;
      tick(1);
      reset_score = 1'b0;
      check("score_rst_ready", 32'(ready), 32'd1);
      check("score_rst_xpos", 32'(shot_xpos), 32'd0);
      tick(10);

`ifdef TRIGGER_AUTOFIRE_EN
      // Held trigger refires every 15 cycles.
      trigger_in = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick(1);
         check("auto_shot", 32'(shot_fired), 32'(k == 7 || k == 22 || k == 37 || k == 52));
      end
      trigger_in = 1'b0;
      tick(30);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
